// File: rtl/vga_640x480_timing.sv
// Free-running VGA timing generator: pixel/line counters advanced on a pixel strobe,
// with sync, visible-area and event flags decoded combinationally from the counters.
module vga_640x480_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pix_stb,
   output logic       o_hs,
   output logic       o_vs,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_active,
   output logic       o_blanking,
   output logic       o_screenend,
   output logic       o_animate
);

   localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ANIM       = 10'(H_ACTIVE - 1);
   localparam logic [9:0] V_ANIM       = 10'(V_ACTIVE - 1);
   localparam logic [8:0] Y_CLAMP      = 9'(V_ACTIVE - 1);

   logic [9:0] h_cnt_reg, h_cnt_next;
   logic [9:0] v_cnt_reg, v_cnt_next;
   logic       h_visible, v_visible;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   always_comb begin
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      if (i_pix_stb) begin
         if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
         end else begin
            h_cnt_next = h_cnt_reg + 10'd1;
         end
      end
   end

   assign h_visible = (h_cnt_reg < H_ACT);
   assign v_visible = (v_cnt_reg < V_ACT);

   assign o_hs        = ~((h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END));
   assign o_vs        = ~((v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END));
   assign o_active    = h_visible && v_visible;
   assign o_blanking  = ~(h_visible && v_visible);
   // Clamped coordinates keep frame-buffer indices legal during blanking.
   assign o_x         = h_visible ? h_cnt_reg : '0;
   assign o_y         = v_visible ? v_cnt_reg[8:0] : Y_CLAMP;
   assign o_screenend = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
   assign o_animate   = (h_cnt_reg == H_ANIM) && (v_cnt_reg == V_ANIM);

endmodule

// File: tb/tb_vga_640x480_timing.sv
// Bench for vga_640x480_timing: a full-size instance for line-level behaviour and a
// shrunken-geometry instance so whole frames fit in a short run.
module tb_vga_640x480_timing;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [9:0] x;
      logic [8:0] y;
      logic       active;
      logic       blank;
      logic       se;
      logic       anim;
   } out_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, stb_a = 1'b0, rst_b = 1'b1, stb_b = 1'b0;
   logic hs_a, vs_a, act_a, blk_a, se_a, anim_a;
   logic hs_b, vs_b, act_b, blk_b, se_b, anim_b;
   logic [9:0] x_a, x_b;
   logic [8:0] y_a, y_b;

   int tests = 0, failed = 0;
   int n_a = 0, n_b = 0;   // strobes accepted since last reset

   vga_640x480_timing dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_pix_stb(stb_a),
      .o_hs(hs_a), .o_vs(vs_a), .o_x(x_a), .o_y(y_a),
      .o_active(act_a), .o_blanking(blk_a), .o_screenend(se_a), .o_animate(anim_a)
   );

   // 29 x 19 frame (551 strobes) with the same porch/sync structure.
   vga_640x480_timing #(
      .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_pix_stb(stb_b),
      .o_hs(hs_b), .o_vs(vs_b), .o_x(x_b), .o_y(y_b),
      .o_active(act_b), .o_blanking(blk_b), .o_screenend(se_b), .o_animate(anim_b)
   );

   // Expected outputs from the raster position reached after n strobes.
   function automatic out_t model(int n, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb);
      int ht, vt, h, v;
      out_t o;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      h  = n % ht;
      v  = (n / ht) % vt;
      o.hs     = !(h >= ha + hf && h < ha + hf + hsw);
      o.vs     = !(v >= va + vf && v < va + vf + vsw);
      o.x      = (h < ha) ? 10'(h) : 10'd0;
      o.y      = (v < va) ? 9'(v) : 9'(va - 1);
      o.active = (h < ha) && (v < va);
      o.blank  = !o.active;
      o.se     = (h == ht - 1) && (v == vt - 1);
      o.anim   = (h == ha - 1) && (v == va - 1);
      return o;
   endfunction

   task automatic chk(string tag, int got, int exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock: update both models from the inputs present at the edge, then compare.
   task automatic tick(string tag);
      out_t ga, gb, ea, eb;
      @(posedge clk);
      #1;
      if (rst_a) n_a = 0; else if (stb_a) n_a++;
      if (rst_b) n_b = 0; else if (stb_b) n_b++;
      ea = model(n_a, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(n_b, 20, 2, 4, 3, 12, 2, 2, 3);
      ga = {hs_a, vs_a, x_a, y_a, act_a, blk_a, se_a, anim_a};
      gb = {hs_b, vs_b, x_b, y_b, act_b, blk_b, se_b, anim_b};
      tests++;
      assert (ga === ea) else begin
         failed++;
         $error("FAIL %s_a got=%h exp=%h n=%0d", tag, ga, ea, n_a);
      end
      tests++;
      assert (gb === eb) else begin
         failed++;
         $error("FAIL %s_b got=%h exp=%h n=%0d", tag, gb, eb, n_b);
      end
   endtask

   initial begin
      int hs_low, blank_cnt, vs_low, se_cnt, anim_cnt, reached;

      // Reset held 3 clocks with strobe toggling.
      for (int i = 0; i < 3; i++) begin
         stb_a = i[0]; stb_b = ~i[0];
         tick("reset");
      end
      chk("reset_x", int'(x_a), 0);
      chk("reset_y", int'(y_a), 0);
      chk("reset_hs", int'(hs_a), 1);
      chk("reset_vs", int'(vs_a), 1);
      chk("reset_active", int'(act_a), 1);
      rst_a = 1'b0; rst_b = 1'b0; stb_a = 1'b0; stb_b = 1'b0;

      // Strobe gating: 50 idle clocks then 10 pulses, one every 4th clock.
      for (int i = 0; i < 50; i++) tick("idle");
      chk("idle_x", int'(x_a), 0);
      for (int i = 0; i < 40; i++) begin
         stb_a = (i % 4 == 3);
         tick("pulse");
      end
      stb_a = 1'b0;
      chk("pulse_x", int'(x_a), 10);

      // Rest of line 0 at full strobe rate, counting sync and blanking pixels.
      hs_low = 0; blank_cnt = 0; reached = 0;
      stb_a = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick("line0");
         if (n_a < 800 && hs_a == 1'b0) hs_low++;
         if (n_a < 800 && act_a == 1'b0) blank_cnt++;
         if (n_a == 800) begin reached = 1; break; end
      end
      stb_a = 1'b0;
      chk("line0_reached", reached, 1);
      chk("hs_low_count", hs_low, 96);
      chk("hblank_count", blank_cnt, 160);
      chk("wrap_x", int'(x_a), 0);
      chk("wrap_y", int'(y_a), 1);

      // Random strobes up to (300,1), then reset mid-line.
      reached = 0;
      for (int i = 0; i < 2000; i++) begin
         if (n_a == 1100) begin reached = 1; break; end
         stb_a = ($urandom_range(0, 3) != 0);
         tick("run_a");
      end
      chk("pos_300_1_reached", reached, 1);
      chk("pre_reset_x", int'(x_a), 300);
      rst_a = 1'b1; stb_a = 1'b1;
      tick("midreset_a");
      rst_a = 1'b0; stb_a = 1'b0;
      chk("midreset_a_x", int'(x_a), 0);
      chk("midreset_a_y", int'(y_a), 0);

      // Small instance: reset, then exactly one frame of strobes.
      rst_b = 1'b1;
      tick("reset_b");
      rst_b = 1'b0; stb_b = 1'b1;
      vs_low = 0; se_cnt = 0; anim_cnt = 0;
      for (int i = 0; i < 551; i++) begin
         tick("frame_b");
         if (vs_b == 1'b0) vs_low++;
         if (se_b) se_cnt++;
         if (anim_b) anim_cnt++;
      end
      stb_b = 1'b0;
      chk("vs_low_count", vs_low, 58);
      chk("screenend_count", se_cnt, 1);
      chk("animate_count", anim_cnt, 1);
      chk("frame_wrap_x", int'(x_b), 0);
      chk("frame_wrap_y", int'(y_b), 0);

      // Random strobes on both instances for two small frames' worth.
      for (int i = 0; i < 1500; i++) begin
         stb_a = ($urandom_range(0, 3) == 0);
         stb_b = ($urandom_range(0, 1) == 1);
         tick("random");
      end

      // Small instance reset at mid-frame position (15,8).
      reached = 0;
      for (int i = 0; i < 3000; i++) begin
         if (n_b % 551 == 8 * 29 + 15) begin reached = 1; break; end
         stb_b = ($urandom_range(0, 2) != 0);
         tick("seek_b");
      end
      chk("pos_15_8_reached", reached, 1);
      rst_b = 1'b1; stb_b = 1'b1;
      tick("midreset_b");
      rst_b = 1'b0;
      chk("midreset_b_x", int'(x_b), 0);
      chk("midreset_b_y", int'(y_b), 0);
      for (int i = 0; i < 100; i++) begin
         stb_b = ($urandom_range(0, 1) == 1);
         tick("restart_b");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
